chunked_addsub: RTL
===================

# chunked_addsub

- Parametrised, multi-cycle adder/subtractor.
- Computes a WIDTH-bit `a + b` or `a - b` CHUNK bits per clock, using a start/busy/done handshake.
- Successor to the fixed 8-bit ripple adder in the arithmetic library. Trades latency for a short carry chain at wide WIDTH.
- Sits between a register-file/controller front end and the result register of the datapath.

## Interface
Parameters:
- `WIDTH`, 8: operand and result width in bits. Must be ≥ 2.
- `CHUNK`, 2: bits processed per cycle. `WIDTH % CHUNK` must be 0. N = WIDTH/CHUNK cycles per operation.

Ports (one clock `clk`; `reset` is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `sub`  in  1  0 = add, 1 = subtract (a - b); sampled with `start`.
- `a`  in  WIDTH  operand A; sampled with `start`.
- `b`  in  WIDTH  operand B; sampled with `start`.
- `busy`  out  1  high while chunks are being computed.
- `done`  out  1  one-cycle pulse; `s`/`cout` are valid in this cycle.
- `s`  out  WIDTH  result.
- `cout`  out  1  final carry. For subtract, 1 = no borrow (a ≥ b unsigned).
- `ovf`  out  1  signed two's-complement overflow. Present only with `CHUNKED_ADDSUB_OVF_EN`.

## Operation
The FSM has three states.

- IDLE (reset state): `busy`=0, `done`=0.
  - On `start`=1: latch `a` and `b_eff = sub ? ~b : b`, set `carry = sub`, set chunk index k = 0, and go to RUN.
- RUN: `busy`=1. Each cycle:
  - Compute `{c, r} = a[k*CHUNK +: CHUNK] + b_eff[k*CHUNK +: CHUNK] + carry`.
  - Write r into `s[k*CHUNK +: CHUNK]` and set `carry = c`.
  - If k = N-1: set `cout = c` (and `ovf`), then go to DONE. Otherwise k = k+1.
- DONE: `done`=1, `busy`=0.
  - With `start`=1: latch the new operands and go to RUN (back-to-back).
  - Otherwise go to IDLE.

Width and hold rules:
- The add result equals the low WIDTH bits of the (WIDTH+1)-bit sum `{cout, s}`.
- The subtract result equals `a - b` mod 2^WIDTH.
- `s`/`cout`/`ovf` hold their last value in IDLE until the next operation starts writing them.
- During RUN, `s` holds partially updated data and is not valid.
- `start` while `busy`=1 is ignored; inputs are not re-sampled mid-operation.
- The internal operand latches are the only source for RUN. Input changes after `start` have no effect.

## Timing
- `start` is sampled at edge E0. Chunks are computed at edges E1..EN. `done`=1 in the cycle after EN.
- Latency: `done` rises N+1 edges after the start edge. With WIDTH=8, CHUNK=2: N=4, so `done` is 5 cycles after `start`.
- Throughput is one result per N+1 cycles when started back-to-back from DONE.
- `reset`=1 at any edge, including mid-RUN, forces the following next-cycle values:
  - State IDLE.
  - `busy`=0, `done`=0.
  - `s`=0, `cout`=0, `ovf`=0.
  - k=0, carry=0.
- The aborted operation produces no `done`.
- `reset` and `start` high at the same edge: reset wins; `start` is discarded.
- CHUNK = WIDTH (N=1): a single RUN cycle, so `done` comes 2 cycles after `start`.

## Configuration
- `CHUNKED_ADDSUB_OVF_EN` defined:
  - The `ovf` port exists.
  - `ovf` is registered at the final RUN edge as (carry into MSB) XOR (carry out of MSB).
  - `ovf` resets to 0 and holds like `s`.
- Not defined: the `ovf` port and its logic are absent. All other behaviour is identical.

## Test plan
All cases use WIDTH=8, CHUNK=2 and the macro defined unless noted.
1. Add with carry out: `a`=0xFF, `b`=0x01, `sub`=0 → `done` 5 cycles after start; `s`=0x00, `cout`=1, `ovf`=0; `busy` high for exactly 4 cycles.
2. Subtract with borrow: `a`=0x05, `b`=0x07, `sub`=1 → `s`=0xFE, `cout`=0, `ovf`=0. Then `a`=0x07, `b`=0x05 → `s`=0x02, `cout`=1.
3. Signed overflow:
   - 0x7F + 0x01 → `s`=0x80, `ovf`=1, `cout`=0.
   - 0x80 - 0x01 → `s`=0x7F, `ovf`=1.
   - Rebuild with the macro undefined → `ovf` port absent, same `s`/`cout`.
4. Busy and back-to-back handshake:
   - Pulse `start` (0x10+0x20) at E0; assert `start` with 0xAA+0x55 while `busy`=1 → first result 0x30, the in-flight start is ignored.
   - `start` (0x01+0x01) in the DONE cycle → second `done` 5 cycles later with `s`=0x02.
5. Reset mid-operation: `reset`=1 at E2 of an 0xFF+0xFF operation → next cycle `busy`=0, `done`=0, `s`=0, `cout`=0. No `done` follows. A fresh 0x03+0x04 then gives `s`=0x07.
6. Parameter sweep: CHUNK=8 (N=1) with 0xC8+0x64 → `s`=0x2C, `cout`=1, `done` 2 cycles after start. WIDTH=32, CHUNK=4 with random operands against the golden `{cout,s}` → latency 9 cycles.

Source files
------------

// File: rtl/chunked_addsub.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock, start/busy/done.
// Define CHUNKED_ADDSUB_OVF_EN to add the registered signed-overflow port ovf.
module chunked_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef CHUNKED_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0]       a_c, b_c, r;
  logic                   c;
  logic                   msb_cin;
  logic                   take;
  logic [WIDTH+CHUNK-1:0] s_sh;

  // Operands shift right each RUN cycle; chunk 0 is always the live one.
  always_comb begin
    a_c     = a_q[CHUNK-1:0];
    b_c     = b_q[CHUNK-1:0];
    {c, r}  = {1'b0, a_c} + {1'b0, b_c}
            + {{CHUNK{1'b0}}, carry_q};
    msb_cin = a_c[CHUNK-1] ^ b_c[CHUNK-1]
            ^ r[CHUNK-1];
    s_sh    = {r, s_q};
    take    = start && (state_q != RUN);
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      RUN: begin
        s_d     = s_sh[WIDTH+CHUNK-1:CHUNK];
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = c;
        if (k_q == KW'(N - 1)) begin
          cout_d  = c;
          ovf_d   = msb_cin ^ c;
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (take) begin
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub;
      k_d     = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign cout = cout_q;
`ifdef CHUNKED_ADDSUB_OVF_EN
  assign ovf  = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule
